// File: rtl/pcs_am_insert.sv
// pcs_am_insert -- 40G/100G PCS alignment-marker insertion.
//
// Every AM_CNT_N+1 slots one slot is reserved for alignment markers. In that
// slot the input is stalled (ready_o=0) and every lane emits its marker block.
// Other slots pass accepted blocks through with one cycle of latency. Marker
// spacing counts accepted blocks, not clock cycles.
//
// Optional feature macro: PCS_AM_BIP_EN. When it is defined, a per-lane BIP-8
// accumulator is kept and its value is written into the marker's BIP3/BIP7
// bytes. Without it, markers carry BIP3=0x00 and BIP7=0xFF.
//
// Ports (pcs_am_insert):
//   clk      single clock
//   nreset   synchronous active-low reset
//   valid_i  all lanes carry a valid block
//   head_i   per-lane sync headers, LANE_N*HEAD_W bits
//   data_i   per-lane scrambled payloads, LANE_N*DATA_W bits
//   ready_o  input accepted when high with valid_i (low in the marker slot)
//   valid_o  output blocks valid
//   am_v_o   output cycle carries alignment markers
//   head_o   per-lane output sync headers
//   data_o   per-lane output payloads
//
// Ports (pcs_am_lane, one per lane):
//   am_slot  current slot is the marker slot
//   take     a data block is accepted this cycle
//   head/data  lane input block; head_q/data_q  registered lane output

module pcs_am_lane #(
  parameter int          DATA_W = 64,
  parameter int          HEAD_W = 2,
  parameter logic [23:0] AM     = 24'h0
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              am_slot,
  input  logic              take,
  input  logic [HEAD_W-1:0] head,
  input  logic [DATA_W-1:0] data,
  output logic [HEAD_W-1:0] head_q,
  output logic [DATA_W-1:0] data_q
);
  localparam logic [HEAD_W-1:0] AM_HEAD = HEAD_W'(2'b10);

  logic [7:0]  bip3;
  logic [63:0] am_word;

  // Byte 0 (M0) sits in the low byte; bytes 4..7 are the inverted copies.
  assign am_word = {~bip3, ~AM[23:16], ~AM[15:8], ~AM[7:0], bip3, AM};

  always_ff @(posedge clk) begin
    if (!nreset) begin
      head_q <= '0;
      data_q <= '0;
    end else if (am_slot) begin
      head_q <= AM_HEAD;
      data_q <= DATA_W'(am_word);
    end else if (take) begin
      head_q <= head;
      data_q <= data;
    end
  end

`ifdef PCS_AM_BIP_EN
  // BIP-8 lane map: payload bit j lands on BIP bit j mod 8; the two sync
  // header bits (transmitted first) land on BIP bits 3 and 4.
  function automatic logic [7:0] bip_of(input logic [HEAD_W-1:0] h,
                                        input logic [DATA_W-1:0] d);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < DATA_W; j++) b[j % 8] = b[j % 8] ^ d[j];
    for (int k = 0; k < HEAD_W; k++) b[(k + 3) % 8] = b[(k + 3) % 8] ^ h[k];
    return b;
  endfunction

  logic [7:0] acc;
  assign bip3 = acc;

  // The marker block restarts the accumulation: its own contribution is the
  // seed for the next period.
  always_ff @(posedge clk) begin
    if (!nreset)      acc <= '0;
    else if (am_slot) acc <= bip_of(AM_HEAD, DATA_W'(am_word));
    else if (take)    acc <= acc ^ bip_of(head, data);
  end
`else
  assign bip3 = 8'h00;
`endif
endmodule

module pcs_am_insert #(
  parameter int                   LANE_N   = 4,
  parameter int                   DATA_W   = 64,
  parameter int                   HEAD_W   = 2,
  parameter int                   AM_CNT_N = 16383,
  parameter logic [LANE_N*24-1:0] AM_LANE  =
    {24'h3D79A2, 24'h9B65C5, 24'hE6C4F0, 24'h477690}
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     valid_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic                     am_v_o,
  output logic [LANE_N*HEAD_W-1:0] head_o,
  output logic [LANE_N*DATA_W-1:0] data_o
);
  localparam int CW = (AM_CNT_N < 1) ? 1 : $clog2(AM_CNT_N + 1);

  logic [CW-1:0] cnt;
  logic          am_slot;
  logic          take;

  assign am_slot = (cnt == '0);
  assign ready_o = !am_slot;
  assign take    = valid_i && !am_slot;

  // Counter only advances on accepted blocks, so idle cycles stretch the
  // period instead of shortening the marker spacing.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt     <= '0;
      valid_o <= 1'b0;
      am_v_o  <= 1'b0;
    end else begin
      valid_o <= am_slot || take;
      am_v_o  <= am_slot;
      if (am_slot)   cnt <= CW'(1);
      else if (take) cnt <= (cnt == CW'(AM_CNT_N)) ? '0 : cnt + CW'(1);
    end
  end

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    pcs_am_lane #(
      .DATA_W (DATA_W),
      .HEAD_W (HEAD_W),
      .AM     (AM_LANE[l*24 +: 24])
    ) u_lane (
      .clk     (clk),
      .nreset  (nreset),
      .am_slot (am_slot),
      .take    (take),
      .head    (head_i[l*HEAD_W +: HEAD_W]),
      .data    (data_i[l*DATA_W +: DATA_W]),
      .head_q  (head_o[l*HEAD_W +: HEAD_W]),
      .data_q  (data_o[l*DATA_W +: DATA_W])
    );
  end
endmodule

// File: doc/pcs_am_insert.md
PCS_AM_INSERT -- requirements
Module: pcs_am_insert

Interface
REQ-001 SHALL have parameter LANE_N, default 4, number of PCS lanes (4 = 40GBASE-R, 20 = 100GBASE-R).
REQ-002 SHALL have parameter DATA_W, default 64, per-lane block payload width.
REQ-003 SHALL have parameter HEAD_W, default 2, per-lane sync header width.
REQ-004 SHALL have parameter AM_CNT_N, default 16383, number of data blocks per lane between alignment markers.
REQ-005 SHALL have parameter AM_LANE, default 40GBASE-R lane 0..3 marker values, LANE_N*24 bits, per-lane {M2,M1,M0}.
REQ-006 SHALL have port clk  input  1  the single clock.
REQ-007 SHALL have port nreset  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port valid_i  input  1  input blocks on all lanes valid.
REQ-009 SHALL have port head_i  input  LANE_N*HEAD_W  per-lane sync headers.
REQ-010 SHALL have port data_i  input  LANE_N*DATA_W  per-lane scrambled payloads.
REQ-011 SHALL have port ready_o  output  1  input accepted this cycle when high with valid_i.
REQ-012 SHALL have port valid_o  output  1  output blocks valid.
REQ-013 SHALL have port am_v_o  output  1  output cycle carries alignment markers.
REQ-014 SHALL have port head_o  output  LANE_N*HEAD_W  per-lane output sync headers.
REQ-015 SHALL have port data_o  output  LANE_N*DATA_W  per-lane output payloads.

Function
REQ-016 SHALL keep a period counter 0..AM_CNT_N; value 0 = marker slot, 1..AM_CNT_N = data slots.
REQ-017 SHALL drive ready_o = 0 in marker slot, 1 in data slots, combinationally from counter state.
REQ-018 SHALL, in marker slot, emit on every lane one marker block regardless of valid_i: valid_o=1, am_v_o=1, head_o=2'b10, data_o bytes {M0,M1,M2,BIP3,~M0,~M1,~M2,~BIP3} (byte 0 first).
REQ-019 SHALL, in a data slot with valid_i=1, register head_i/data_i to outputs with valid_o=1, am_v_o=0, and advance the counter.
REQ-020 SHALL, in a data slot with valid_i=0, drive valid_o=0 and hold the counter; held data_o/head_o values are don't-care.
REQ-021 SHALL wrap counter from AM_CNT_N to 0; from 0 to 1 unconditionally after the marker cycle.
REQ-022 SHALL have fixed latency of one cycle, input acceptance to output.
REQ-023 SHALL keep one BIP accumulator of 8 bits per lane, XORing each emitted 66-bit block bit into BIP bit per IEEE 802.3 Table 82-4.
REQ-024 SHALL, at a marker slot, place accumulator value as BIP3, then load accumulator with the BIP contribution of that emitted marker block alone.
REQ-025 SHALL leave accumulators unchanged on cycles with valid_o=0.
REQ-026 SHALL support any LANE_N in 1..20 and AM_CNT_N >= 1 without RTL changes.

Reset
REQ-027 SHALL, while nreset=0 at clk edge, set counter=0, accumulators=0, valid_o=0, am_v_o=0, head_o=0, data_o=0.
REQ-028 SHALL make the first cycle after reset release a marker slot (ready_o=0) with BIP3=0x00.
REQ-029 SHALL abort any partial period on mid-operation reset; no data block is emitted from a pre-reset acceptance.

Configuration
REQ-030 SHALL compile BIP accumulation only when macro PCS_AM_BIP_EN is defined.
REQ-031 SHALL, without PCS_AM_BIP_EN, omit accumulators and emit BIP3=0x00, BIP7=0xFF in every marker; all other behaviour identical.

Verification
REQ-032 SHALL cover: LANE_N=4, AM_CNT_N=4, valid_i=1 constant after reset -> marker cycles at output cycles 1,6,11; lane0 data_o bytes 0..2 = 0x90,0x76,0x47, lane3 = 0xA2,0x79,0x3D; ready_o low exactly at cycles 0,5,10.
REQ-033 SHALL cover: valid_i toggling 1,0,1,0 in data slots -> valid_o follows one cycle later, marker spacing stretches to 4 accepted blocks, never 4 cycles.
REQ-034 SHALL cover: valid_i=0 during marker slot -> marker still emitted with valid_o=1, am_v_o=1.
REQ-035 SHALL cover: nreset low one cycle after 2nd data block -> next output is marker with BIP3=0x00, then 4 data blocks.
REQ-036 SHALL cover: PCS_AM_BIP_EN defined, random data over 3 periods -> BIP3/BIP7 per lane match bench model bit-for-bit; undefined -> BIP3=0x00, BIP7=0xFF every marker.
